quad_timer_multi: RTL and testbench
===================================

// Module: quad_timer_multi
// PURPOSE
//   NUM_CH-channel compare timer on one shared prescaled free-running counter, Wishbone slave.
//   Each channel has one-shot or periodic (auto-advancing compare) mode, a sticky pending flag
//   and a mask. o_irq = OR of (pending & ie). Successor to the single-compare timer on the SoC
//   peripheral bus; provides the scheduler tick plus independent software deadlines.
// PARAMETERS
//   WIDTH    32  counter/compare/reload width, 8..32; reads zero-extended to 32 bits
//   NUM_CH   4   channel count, 1..7
//   PRESC_W  8   prescaler width; counter ticks once per (PRESCALE+1) clocks
// PORTS
//   i_clk      in   1      clock
//   i_rst_n    in   1      synchronous reset, active low
//   i_wb_addr  in   32     byte address, decoded on [7:2]
//   i_wb_dat   in   32     write data
//   i_wb_we    in   1      write enable
//   i_wb_cyc   in   1      cycle valid (one access per pulse)
//   o_wb_dat   out  32     read data, registered, valid while o_wb_ack=1
//   o_wb_ack   out  1      one-cycle ack, cycle after i_wb_cyc accepted
//   o_irq      out  1      level interrupt, registered
// BEHAVIOUR
//   Register map: 0x00 TIME (RW); 0x04 STATUS (pending[NUM_CH-1:0], W1C); 0x08 PRESCALE (RW);
//     channel n at 0x10*(n+1): +0 CMP (RW), +4 CTRL (RW: [0]en [1]periodic [2]ie), +8 RELOAD (RW).
//     Unmapped/absent-channel reads return 0; writes ignored. Write bits above WIDTH dropped.
//   Reset (i_rst_n=0 at clock edge): TIME, CMP, RELOAD, PRESCALE, prescale count, CTRL, pending = 0;
//     o_wb_ack=0, o_wb_dat=0, o_irq=0. Reset mid-access: access dropped, no ack.
//   Wishbone: access accepted on any cycle with i_wb_cyc=1 and o_wb_ack=0; ack next cycle;
//     i_wb_cyc held through ack is not a second access. Read data = register value at accept edge.
//   Prescaler: pcnt increments each clock; when pcnt==PRESCALE, pcnt<=0 and tick=1 that cycle.
//     PRESCALE=0 -> tick every clock. PRESCALE write resets pcnt to 0.
//   Counter: on tick TIME<=TIME+1 mod 2^WIDTH (wraps all-ones -> 0, no flag).
//     TIME write loads value, overrides that cycle's increment, and suppresses matches that cycle.
//   Match (per channel, tick cycles only): en && (TIME+1)==CMP -> pending[n]<=1 at same edge as
//     TIME becomes CMP. Then periodic=1: CMP<=CMP+RELOAD mod 2^WIDTH, en stays 1;
//     periodic=0: en<=0 (one-shot). RELOAD=0 in periodic: CMP unchanged, re-match after 2^WIDTH ticks.
//   Priorities: SW write to CMP/CTRL same cycle as match -> SW value wins (no auto-advance), but
//     pending is still set. W1C on STATUS same cycle as new match on that bit -> set wins.
//   Pending is sticky, independent of ie; clearing en does not clear pending.
//   o_irq registered: asserts cycle after pending&ie becomes nonzero, drops cycle after it clears.
// TESTING
//   Reset: drive i_rst_n=0 2 clocks -> all reads 0, o_irq=0, TIME stays 0 while reset held.
//   One-shot: PRESCALE=0, CH0 CMP=0xF0, CTRL=0x5 -> pending[0] and o_irq after TIME reaches 0xF0
//     (o_irq 1 cycle later); CTRL reads 0x4; W1C STATUS=0x1 -> o_irq low next cycle, no re-fire.
//   Periodic: CH1 CMP=0x20 RELOAD=0x10 CTRL=0x7, PRESCALE=3 -> pending at TIME 0x20,0x30,0x40;
//     tick every 4 clocks; CMP reads 0x50 after third match.
//   Wrap: WIDTH=8 build, TIME=0xFE, CH2 CMP=0x02 periodic RELOAD=0xFC -> matches at 0x02 then 0xFE.
//   Collisions: W1C STATUS on exact match edge -> pending stays 1; CMP write on match edge ->
//     written value kept, pending set; TIME write on match edge -> no match.
//   Masking/bus: ie=0 match -> pending=1, o_irq=0; set ie -> o_irq next cycle; read 0x7C with
//     NUM_CH=4 -> 0 with ack; held i_wb_cyc yields exactly one ack per pulse.

Source files
------------

// File: rtl/quad_timer_multi.sv
// Multi-channel compare timer: one shared prescaled free-running counter, NUM_CH compare
// channels (one-shot or auto-advancing periodic), sticky pending flags, Wishbone slave.
module quad_timer_multi #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned PRESC_W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_irq
);

   logic [WIDTH-1:0]   time_q;
   logic [WIDTH-1:0]   time_inc;
   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] pcnt_q;
   logic [WIDTH-1:0]   cmp_q  [NUM_CH];
   logic [WIDTH-1:0]   rel_q  [NUM_CH];
   logic [2:0]         ctrl_q [NUM_CH];
   logic [NUM_CH-1:0]  pend_q;
   logic [NUM_CH-1:0]  hit;
   logic [NUM_CH-1:0]  ie;
   logic [NUM_CH-1:0]  wr_cmp;
   logic [NUM_CH-1:0]  wr_ctrl;
   logic [NUM_CH-1:0]  wr_rel;
   logic [NUM_CH-1:0]  clr;
   logic               acc;
   logic               wr;
   logic               wr_time;
   logic               wr_stat;
   logic               wr_presc;
   logic               tick;
   logic [5:0]         widx;
   logic [WIDTH-1:0]   wd;
   logic [31:0]        rd;
   logic               unused_bits;

   assign unused_bits = ^{i_wb_addr[31:8], i_wb_addr[1:0], i_wb_dat};

   always_comb begin
      acc      = i_wb_cyc && !o_wb_ack;
      wr       = acc && i_wb_we;
      widx     = i_wb_addr[7:2];
      wd       = i_wb_dat[WIDTH-1:0];
      wr_time  = wr && (widx == 6'd0);
      wr_stat  = wr && (widx == 6'd1);
      wr_presc = wr && (widx == 6'd2);
      clr      = wr_stat ? i_wb_dat[NUM_CH-1:0] : '0;
      tick     = (pcnt_q == presc_q);
      time_inc = time_q + WIDTH'(1);
      wr_cmp   = '0;
      wr_ctrl  = '0;
      wr_rel   = '0;
      hit      = '0;
      ie       = '0;
      rd       = '0;
      case (widx)
         6'd0:    rd[WIDTH-1:0]   = time_q;
         6'd1:    rd[NUM_CH-1:0]  = pend_q;
         6'd2:    rd[PRESC_W-1:0] = presc_q;
         default: ;
      endcase
      for (int unsigned n = 0; n < NUM_CH; n++) begin
         wr_cmp[n]  = wr && (widx == 6'(4*n + 4));
         wr_ctrl[n] = wr && (widx == 6'(4*n + 5));
         wr_rel[n]  = wr && (widx == 6'(4*n + 6));
         ie[n]      = ctrl_q[n][2];
         // Compare against the incremented value so pending rises on the edge TIME becomes CMP.
         hit[n]     = tick && !wr_time && ctrl_q[n][0] && (time_inc == cmp_q[n]);
         if (widx == 6'(4*n + 4)) rd[WIDTH-1:0] = cmp_q[n];
         if (widx == 6'(4*n + 5)) rd[2:0]       = ctrl_q[n];
         if (widx == 6'(4*n + 6)) rd[WIDTH-1:0] = rel_q[n];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         time_q   <= '0;
         presc_q  <= '0;
         pcnt_q   <= '0;
         pend_q   <= '0;
         o_wb_ack <= 1'b0;
         o_wb_dat <= '0;
         o_irq    <= 1'b0;
         for (int unsigned n = 0; n < NUM_CH; n++) begin
            cmp_q[n]  <= '0;
            rel_q[n]  <= '0;
            ctrl_q[n] <= '0;
         end
      end else begin
         o_wb_ack <= acc;
         if (acc) o_wb_dat <= rd;

         if (wr_presc) begin
            presc_q <= i_wb_dat[PRESC_W-1:0];
            pcnt_q  <= '0;
         end else begin
            pcnt_q <= tick ? '0 : pcnt_q + PRESC_W'(1);
         end

         if (wr_time)   time_q <= wd;
         else if (tick) time_q <= time_inc;

         // A software write to CMP/CTRL on a match edge takes precedence over the auto-update.
         for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (wr_cmp[n])                         cmp_q[n] <= wd;
            else if (hit[n] && ctrl_q[n][1])       cmp_q[n] <= cmp_q[n] + rel_q[n];
            if (wr_ctrl[n])                        ctrl_q[n] <= i_wb_dat[2:0];
            else if (hit[n] && !ctrl_q[n][1])      ctrl_q[n][0] <= 1'b0;
            if (wr_rel[n])                         rel_q[n] <= wd;
         end

         pend_q <= (pend_q & ~clr) | hit;
         o_irq  <= |(pend_q & ie);
      end
   end

endmodule

// File: tb/tb_quad_timer_multi.sv
// Directed self-checking bench: a 32-bit instance for the main scenarios and an 8-bit
// instance for counter wrap and write truncation; all timing is cycle-counted from access edges.
module tb_quad_timer_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr0, wdat0, rdat0, addr8, wdat8, rdat8;
   logic        we0, cyc0, ack0, irq0, we8, cyc8, ack8, irq8;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   quad_timer_multi #(.WIDTH(32), .NUM_CH(4), .PRESC_W(8)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_addr(addr0), .i_wb_dat(wdat0), .i_wb_we(we0),
      .i_wb_cyc(cyc0), .o_wb_dat(rdat0), .o_wb_ack(ack0), .o_irq(irq0)
   );

   quad_timer_multi #(.WIDTH(8), .NUM_CH(4), .PRESC_W(8)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_addr(addr8), .i_wb_dat(wdat8), .i_wb_we(we8),
      .i_wb_cyc(cyc8), .o_wb_dat(rdat8), .o_wb_ack(ack8), .o_irq(irq8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Accepted on the first edge after the call; returns #1 after the following (ack) edge.
   task automatic wb_acc(input bit s, input bit we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic ack);
      if (s) begin cyc8 = 1'b1; we8 = we; addr8 = a; wdat8 = d; end
      else   begin cyc0 = 1'b1; we0 = we; addr0 = a; wdat0 = d; end
      @(posedge clk); #1;
      ack = s ? ack8 : ack0;
      rd  = s ? rdat8 : rdat0;
      cyc0 = 1'b0; we0 = 1'b0; cyc8 = 1'b0; we8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input bit s, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        ack;
      wb_acc(s, 1'b1, a, d, rd, ack);
   endtask

   task automatic rd_chk(input bit s, input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] rd;
      logic        ack;
      wb_acc(s, 1'b0, a, 32'h0, rd, ack);
      check(tag, rd, exp);
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rdv;
      logic        ackv;
      int          acks;

      // Reset held two edges with a bus request pending: no ack, outputs zero.
      rst_n = 1'b0;
      cyc0 = 1'b1; we0 = 1'b0; addr0 = '0; wdat0 = '0;
      cyc8 = 1'b0; we8 = 1'b0; addr8 = '0; wdat8 = '0;
      wait_cyc(2);
      check("rst_ack", ack0, 0);
      check("rst_dat", rdat0, 0);
      check("rst_irq", irq0, 0);
      check("rst_irq8", irq8, 0);
      rst_n = 1'b1;
      cyc0  = 1'b0;
      rd_chk(0, 32'h00, 32'h0, "rst_time");
      rd_chk(0, 32'h04, 32'h0, "rst_status");
      rd_chk(0, 32'h08, 32'h0, "rst_presc");
      rd_chk(0, 32'h10, 32'h0, "rst_cmp0");
      rd_chk(0, 32'h14, 32'h0, "rst_ctrl0");
      rd_chk(0, 32'h18, 32'h0, "rst_rel0");

      // One-shot on CH0, PRESCALE=0. TIME=0xE0 at edge T -> 0xF0 at T+16, o_irq at T+17.
      wr(0, 32'h10, 32'hF0);
      wr(0, 32'h00, 32'hE0);
      wr(0, 32'h14, 32'h5);
      wait_cyc(13);
      check("os_irq_pre", irq0, 0);
      wait_cyc(1);
      check("os_irq", irq0, 1);
      rd_chk(0, 32'h14, 32'h4, "os_ctrl");
      rd_chk(0, 32'h04, 32'h1, "os_status");
      wr(0, 32'h04, 32'h1);
      check("os_w1c_irq", irq0, 0);
      wait_cyc(5);
      rd_chk(0, 32'h04, 32'h0, "os_no_refire");

      // Periodic on CH1, PRESCALE=3 written at P: ticks at P+4k; TIME=0x1C at P+2.
      wr(0, 32'h20, 32'h20);
      wr(0, 32'h28, 32'h10);
      wr(0, 32'h08, 32'h3);
      wr(0, 32'h00, 32'h1C);
      wr(0, 32'h24, 32'h7);
      wait_cyc(11);
      check("per1_irq_pre", irq0, 0);
      wait_cyc(1);
      check("per1_irq", irq0, 1);
      rd_chk(0, 32'h00, 32'h20, "per1_time");
      rd_chk(0, 32'h04, 32'h2, "per1_status");
      wr(0, 32'h04, 32'h2);
      check("per1_w1c_irq", irq0, 0);
      rd_chk(0, 32'h20, 32'h30, "per1_cmp");
      wait_cyc(55);
      check("per2_irq_pre", irq0, 0);
      wait_cyc(1);
      check("per2_irq", irq0, 1);
      rd_chk(0, 32'h00, 32'h30, "per2_time");
      wr(0, 32'h04, 32'h2);
      wait_cyc(59);
      check("per3_irq_pre", irq0, 0);
      wait_cyc(1);
      check("per3_irq", irq0, 1);
      rd_chk(0, 32'h20, 32'h50, "per3_cmp");
      rd_chk(0, 32'h04, 32'h2, "per3_status");
      wr(0, 32'h24, 32'h0);
      wr(0, 32'h04, 32'h2);
      wr(0, 32'h08, 32'h0);

      // Collision: W1C lands on the CH2 match edge T+16 -> pending stays set.
      wr(0, 32'h30, 32'h100);
      wr(0, 32'h00, 32'hF0);
      wr(0, 32'h34, 32'h1);
      wait_cyc(12);
      wr(0, 32'h04, 32'h4);
      rd_chk(0, 32'h04, 32'h4, "col_w1c_pend");
      rd_chk(0, 32'h34, 32'h0, "col_oneshot_en");
      wr(0, 32'h04, 32'h4);

      // Collision: CMP write on a periodic match edge -> written value kept, pending set.
      wr(0, 32'h38, 32'h10);
      wr(0, 32'h00, 32'hF0);
      wr(0, 32'h34, 32'h3);
      wait_cyc(12);
      wr(0, 32'h30, 32'h200);
      rd_chk(0, 32'h30, 32'h200, "col_cmp_kept");
      rd_chk(0, 32'h04, 32'h4, "col_cmp_pend");
      wr(0, 32'h34, 32'h0);
      wr(0, 32'h04, 32'h4);

      // Collision: TIME write on the match edge -> no match, channel still enabled.
      wr(0, 32'h00, 32'h1F0);
      wr(0, 32'h34, 32'h1);
      wait_cyc(12);
      wr(0, 32'h00, 32'h500);
      rd_chk(0, 32'h04, 32'h0, "col_time_nomatch");
      rd_chk(0, 32'h34, 32'h1, "col_time_en");
      wr(0, 32'h34, 32'h0);

      // Masking on CH3: match with ie=0, then ie set with en cleared.
      wr(0, 32'h40, 32'h600);
      wr(0, 32'h00, 32'h5F0);
      wr(0, 32'h44, 32'h1);
      wait_cyc(20);
      rd_chk(0, 32'h04, 32'h8, "mask_pend");
      check("mask_irq_off", irq0, 0);
      wr(0, 32'h44, 32'h4);
      check("mask_irq_on", irq0, 1);
      rd_chk(0, 32'h04, 32'h8, "mask_pend_kept");
      wr(0, 32'h04, 32'h8);
      check("mask_irq_clr", irq0, 0);

      // Bus: unmapped and absent-channel reads, and a cycle held through its ack.
      wb_acc(0, 1'b0, 32'h7C, 32'h0, rdv, ackv);
      check("unmapped_rd", rdv, 0);
      check("unmapped_ack", ackv, 1);
      rd_chk(0, 32'h50, 32'h0, "absent_ch");
      cyc0 = 1'b1; we0 = 1'b0; addr0 = 32'h08;
      acks = 0;
      @(posedge clk); #1; acks += int'(ack0);
      @(posedge clk); #1; acks += int'(ack0);
      cyc0 = 1'b0;
      @(posedge clk); #1; acks += int'(ack0);
      check("held_acks", acks, 1);

      // 8-bit instance: truncation, then wrap. TIME=0xFE at T -> 0x02 at T+4, 0xFE at T+256.
      wr(1, 32'h30, 32'h02);
      wr(1, 32'h38, 32'hFC);
      wr(1, 32'h20, 32'h1AB);
      rd_chk(1, 32'h20, 32'hAB, "w8_trunc");
      wr(1, 32'h00, 32'hFE);
      wr(1, 32'h34, 32'h7);
      wait_cyc(1);
      check("wrap1_irq_pre", irq8, 0);
      wait_cyc(1);
      check("wrap1_irq", irq8, 1);
      rd_chk(1, 32'h30, 32'hFE, "wrap1_cmp");
      wr(1, 32'h04, 32'h4);
      check("wrap1_w1c_irq", irq8, 0);
      wait_cyc(247);
      check("wrap2_irq_pre", irq8, 0);
      wait_cyc(1);
      check("wrap2_irq", irq8, 1);
      rd_chk(1, 32'h30, 32'hFA, "wrap2_cmp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
